// File: rtl/hv_pkg.sv
// Shared defaults and saturating arithmetic for the hypervector bundling stage.
package hv_pkg;
   localparam int CNT_W_DEF = 16;

   // Signed add clamped symmetrically to +-lim, so counters never wrap.
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int lim);
      logic signed [31:0] s;
      s = a + b;
      if (s > lim) return lim;
      if (s < -lim) return -lim;
      return s;
   endfunction
endpackage

// File: rtl/bit_bundle_counter.sv
// One dimension of the bundler: signed vote counter over the active cores plus sign/tie output.
module bit_bundle_counter
   import hv_pkg::*;
#(
   parameter int N_CORES = 32,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [N_CORES-1:0] i_bits,
   input  logic [N_CORES-1:0] i_active,
   input  logic               i_update,
   input  logic               i_clear,
   input  logic               i_tie,
   output logic               o_sign
);
   localparam int LIM = (1 << (CNT_W-1)) - 1;

   logic signed [CNT_W-1:0] r_acc;
   logic signed [31:0]      w_pop;
   logic signed [31:0]      w_nact;
   logic signed [31:0]      w_delta;
   logic signed [31:0]      w_base;

   always_comb begin
      w_pop  = '0;
      w_nact = '0;
      for (int j = 0; j < N_CORES; j++) begin
         if (i_active[j]) begin
            w_nact = w_nact + 32'sd1;
            if (i_bits[j]) w_pop = w_pop + 32'sd1;
         end
      end
      w_delta = 32'sd2 * w_pop - w_nact;
   end

   // A clear with a concurrent update starts the next bundle from this update's votes.
   assign w_base = i_clear ? 32'sd0 : {{(32-CNT_W){r_acc[CNT_W-1]}}, r_acc};

   always_ff @(posedge i_clk) begin
      if (i_rst)         r_acc <= '0;
      else if (i_update) r_acc <= CNT_W'(sat_add(w_base, w_delta, LIM));
      else if (i_clear)  r_acc <= '0;
   end

   assign o_sign = (r_acc > 0) ? 1'b1 : (r_acc < 0) ? 1'b0 : i_tie;
endmodule

// File: rtl/hv_bundle_buffer.sv
// Bundling stage: per-dimension vote counters thresholded into a sign vector,
// queued in a small FIFO and streamed out over valid/ready.
module hv_bundle_buffer
   import hv_pkg::*;
#(
   parameter int N_CORES = 32,
   parameter int DIM     = 32,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int DEPTH   = 4,
   localparam int RW     = $clog2(N_CORES),
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [N_CORES*DIM-1:0] i_core_result,
   input  logic [DIM-1:0]         i_tmp_rand,
   input  logic [RW-1:0]          i_remainder,
   input  logic                   i_update,
   input  logic                   i_last_update,
   input  logic                   i_get_fin,
   input  logic                   i_stream_ready,
   output logic                   o_stream_v,
   output logic [DIM-1:0]         o_stream_d,
   output logic [AW:0]            o_fifo_count,
   output logic                   o_overflow
);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [N_CORES-1:0]            w_active;
   logic [DIM-1:0][N_CORES-1:0]   w_bits;
   logic [DIM-1:0]                w_sign;

   logic [DIM-1:0]                r_mem [DEPTH];
   logic [AW-1:0]                 r_wptr, r_rptr, w_rptr_n;
   logic [AW:0]                   r_count, w_count_n;
   logic                          r_stream_v, r_overflow;
   logic [DIM-1:0]                r_stream_d, w_head_n;
   logic                          w_full, w_pop, w_push;

   always_comb begin
      w_active = '1;
      for (int j = 0; j < N_CORES; j++)
         w_active[j] = !(i_last_update && (i_remainder != '0) && (j >= int'(i_remainder)));
   end

   for (genvar d = 0; d < DIM; d++) begin : g_dim
      for (genvar j = 0; j < N_CORES; j++) begin : g_core
         assign w_bits[d][j] = i_core_result[j*DIM + d];
      end
      bit_bundle_counter #(.N_CORES(N_CORES), .CNT_W(CNT_W)) u_cnt (
         .i_clk    (i_clk),
         .i_rst    (i_rst),
         .i_bits   (w_bits[d]),
         .i_active (w_active),
         .i_update (i_update),
         .i_clear  (i_get_fin),
         .i_tie    (i_tmp_rand[d]),
         .o_sign   (w_sign[d])
      );
   end

   // A pop frees a slot in the same cycle, so a full FIFO can still accept get_fin.
   assign w_full   = (r_count == FULL_CNT);
   assign w_pop    = r_stream_v && i_stream_ready;
   assign w_push   = i_get_fin && (!w_full || w_pop);
   assign w_rptr_n = r_rptr + AW'(w_pop);

   always_comb begin
      w_count_n = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_n = r_count + 1'b1;
         2'b01:   w_count_n = r_count - 1'b1;
         default: w_count_n = r_count;
      endcase
      // The next head is the incoming vector when it lands in the slot being exposed.
      w_head_n = (w_push && (r_wptr == w_rptr_n)) ? w_sign : r_mem[w_rptr_n];
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= w_sign;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_stream_v <= 1'b0;
         r_stream_d <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         r_rptr     <= w_rptr_n;
         r_count    <= w_count_n;
         r_stream_v <= (w_count_n != '0);
         if (w_count_n != '0) r_stream_d <= w_head_n;
         if (i_get_fin && !w_push) r_overflow <= 1'b1;
      end
   end

   assign o_stream_v   = r_stream_v;
   assign o_stream_d   = r_stream_d;
   assign o_fifo_count = r_count;
   assign o_overflow   = r_overflow;
endmodule

// File: tb/tb_hv_bundle_buffer.sv
// Directed bench: main instance (N_CORES=4, DIM=8, CNT_W=8, DEPTH=4) plus a CNT_W=4 instance for clamping.
module tb_hv_bundle_buffer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] a_core = '0;
   logic [7:0]  a_tmp  = '0;
   logic [1:0]  a_rem  = '0;
   logic        a_upd = 1'b0, a_last = 1'b0, a_fin = 1'b0, a_rdy = 1'b0;
   logic        a_v, a_ovf;
   logic [7:0]  a_d;
   logic [2:0]  a_cnt;

   logic [31:0] b_core = '0;
   logic [7:0]  b_tmp  = '0;
   logic [1:0]  b_rem  = '0;
   logic        b_upd = 1'b0, b_last = 1'b0, b_fin = 1'b0, b_rdy = 1'b0;
   logic        b_v, b_ovf;
   logic [7:0]  b_d;
   logic [2:0]  b_cnt;

   hv_bundle_buffer #(.N_CORES(4), .DIM(8), .CNT_W(8), .DEPTH(4)) u_dut_a (
      .i_clk(clk), .i_rst(rst), .i_core_result(a_core), .i_tmp_rand(a_tmp),
      .i_remainder(a_rem), .i_update(a_upd), .i_last_update(a_last), .i_get_fin(a_fin),
      .i_stream_ready(a_rdy), .o_stream_v(a_v), .o_stream_d(a_d),
      .o_fifo_count(a_cnt), .o_overflow(a_ovf)
   );

   hv_bundle_buffer #(.N_CORES(4), .DIM(8), .CNT_W(4), .DEPTH(4)) u_dut_b (
      .i_clk(clk), .i_rst(rst), .i_core_result(b_core), .i_tmp_rand(b_tmp),
      .i_remainder(b_rem), .i_update(b_upd), .i_last_update(b_last), .i_get_fin(b_fin),
      .i_stream_ready(b_rdy), .o_stream_v(b_v), .o_stream_d(b_d),
      .o_fifo_count(b_cnt), .o_overflow(b_ovf)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp_t5 [3];
      exp_t5[0] = 8'h33; exp_t5[1] = 8'h44; exp_t5[2] = 8'h55;

      tick(); tick();
      rst = 1'b0;
      check("rst_v",   32'(a_v),   32'd0);
      check("rst_d",   32'(a_d),   32'd0);
      check("rst_cnt", 32'(a_cnt), 32'd0);
      check("rst_ovf", 32'(a_ovf), 32'd0);

      // single update, all cores A5
      a_core = {4{8'hA5}}; a_upd = 1'b1; tick();
      a_upd = 1'b0; a_fin = 1'b1; a_rdy = 1'b1; tick();
      a_fin = 1'b0;
      check("t1_v",   32'(a_v),   32'd1);
      check("t1_d",   32'(a_d),   32'hA5);
      check("t1_cnt", 32'(a_cnt), 32'd1);
      tick();
      check("t1_cnt0", 32'(a_cnt), 32'd0);
      check("t1_v0",   32'(a_v),   32'd0);
      check("t1_hold", 32'(a_d),   32'hA5);

      // every dimension ties
      a_core = {8'h00, 8'h00, 8'hFF, 8'hFF}; a_upd = 1'b1; tick();
      a_upd = 1'b0; a_tmp = 8'h3C; a_fin = 1'b1; tick();
      a_fin = 1'b0;
      check("t2_tie", 32'(a_d), 32'h3C);
      tick();

      // remainder mask, core3 excluded
      a_last = 1'b1; a_rem = 2'd3; a_core = {8'hFF, 8'h00, 8'h00, 8'h00}; a_upd = 1'b1; tick();
      a_upd = 1'b0; a_last = 1'b0; a_tmp = 8'hFF; a_fin = 1'b1; tick();
      a_fin = 1'b0;
      check("t3_mask", 32'(a_d), 32'h00);
      tick();
      a_last = 1'b1; a_core = {8'hFF, 8'hFF, 8'h00, 8'h00}; a_upd = 1'b1; tick();
      a_upd = 1'b0; a_last = 1'b0; a_fin = 1'b1; tick();
      a_fin = 1'b0;
      check("t3_mask_tie", 32'(a_d), 32'h00);
      tick();
      a_last = 1'b1; a_core = {4{8'hFF}}; tick();
      a_last = 1'b0; a_tmp = 8'h96; a_fin = 1'b1; tick();
      a_fin = 1'b0;
      check("t3_last_noupd", 32'(a_d), 32'h96);
      tick();

      // update in the get_fin cycle opens the next bundle
      a_rem = 2'd0; a_core = {4{8'h0F}}; a_upd = 1'b1; tick();
      a_core = {4{8'hF0}}; a_fin = 1'b1; a_tmp = 8'h00; tick();
      a_upd = 1'b0;
      check("ts_d0",  32'(a_d),   32'h0F);
      check("ts_c0",  32'(a_cnt), 32'd1);
      tick();
      a_fin = 1'b0;
      check("ts_d1",  32'(a_d),   32'hF0);
      check("ts_c1",  32'(a_cnt), 32'd1);
      tick();
      check("ts_c2",  32'(a_cnt), 32'd0);

      // overflow with back-pressure, then drain
      a_rdy = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         a_tmp = 8'(k); a_fin = 1'b1; tick();
      end
      a_fin = 1'b0;
      check("t4_cnt",  32'(a_cnt), 32'd4);
      check("t4_ovf",  32'(a_ovf), 32'd1);
      check("t4_v",    32'(a_v),   32'd1);
      check("t4_d1",   32'(a_d),   32'h01);
      tick();
      check("t4_stall", 32'(a_d),  32'h01);
      a_rdy = 1'b1;
      for (int k = 2; k <= 4; k++) begin
         tick();
         check("t4_drain", 32'(a_d),   32'(k));
         check("t4_dcnt",  32'(a_cnt), 32'(5 - k));
      end
      tick();
      check("t4_empty", 32'(a_v),   32'd0);
      check("t4_ehold", 32'(a_d),   32'h04);
      check("t4_sticky", 32'(a_ovf), 32'd1);
      a_rdy = 1'b0; rst = 1'b1; tick();
      rst = 1'b0;
      check("t4_ovf_clr", 32'(a_ovf), 32'd0);

      // full FIFO with simultaneous push and pop
      foreach (exp_t5[i]) begin end
      for (int k = 1; k <= 4; k++) begin
         a_tmp = 8'(k * 8'h11); a_fin = 1'b1; tick();
      end
      a_tmp = 8'h55; a_rdy = 1'b1; tick();
      a_fin = 1'b0;
      check("t5_cnt", 32'(a_cnt), 32'd4);
      check("t5_ovf", 32'(a_ovf), 32'd0);
      check("t5_d",   32'(a_d),   32'h22);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t5_order", 32'(a_d), 32'(exp_t5[k]));
      end
      tick();
      check("t5_empty", 32'(a_v), 32'd0);

      // reset with data queued, overflow set and a bundle in progress
      a_rdy = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         a_tmp = 8'(k * 8'h11); a_fin = 1'b1; tick();
      end
      a_fin = 1'b0; a_core = {4{8'hA5}}; a_upd = 1'b1; tick();
      a_upd = 1'b0; rst = 1'b1; tick();
      rst = 1'b0;
      check("rst2_v",   32'(a_v),   32'd0);
      check("rst2_d",   32'(a_d),   32'd0);
      check("rst2_cnt", 32'(a_cnt), 32'd0);
      check("rst2_ovf", 32'(a_ovf), 32'd0);
      a_tmp = 8'h5A; a_fin = 1'b1; tick();
      a_fin = 1'b0;
      check("rst2_acc", 32'(a_d), 32'h5A);

      // CNT_W=4: saturate at +7, then walk down with odd and even deltas
      b_rdy = 1'b1; b_core = {4{8'hFF}}; b_upd = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      b_last = 1'b1; b_rem = 2'd3; b_core = '0;
      tick(); tick();
      b_upd = 1'b0; b_last = 1'b0; b_tmp = 8'h00; b_fin = 1'b1; tick();
      b_fin = 1'b0;
      check("clamp_odd", 32'(b_d), 32'hFF);
      tick();
      b_core = {4{8'hFF}}; b_upd = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      b_core = '0; b_rem = 2'd0;
      tick(); tick();
      b_upd = 1'b0; b_tmp = 8'hFF; b_fin = 1'b1; tick();
      b_fin = 1'b0;
      check("clamp_even", 32'(b_d), 32'h00);
      tick();
      check("clamp_empty", 32'(b_v), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
